frv_dmem_sram: RTL and testbench

FRV_DMEM_SRAM -- requirements
Module: frv_dmem_sram

---
 rtl/frv_dmem_sram.sv | 182 ++++++++++++++++++
 tb/tb_frv_dmem_sram.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_dmem_sram.sv
//------------------------------------------------------------------------------
// frv_dmem_sram
//
// Adapts the core data port (req/gnt request, recv/ack response) to a
// single-port synchronous SRAM with one cycle of read latency.
//
// Each accepted request drives the SRAM in the accept cycle and loads a
// one-entry inflight register. In the following cycle the SRAM read data is
// available, and the response is pushed into a 4-entry response FIFO. The
// core then sees the response two cycles after the accept.
//
// Parameters
//   BASE_ADDR  byte base address of the SRAM window (aligned to 2^SIZE_W)
//   SIZE_W     log2 of the window size in bytes (>= 3)
//
// Ports
//   g_clk, g_resetn        clock, asynchronous active-low reset
//   mem_req/wen/strb/wdata/addr   request from the core
//   mem_gnt                request accepted this cycle
//   mem_recv/error/rdata   response from the FIFO head
//   mem_ack                core consumes the response at the head
//   sram_cs/wen/strb/addr/wdata   SRAM access, driven in the accept cycle
//   sram_rdata             SRAM read data, valid the cycle after a read
//------------------------------------------------------------------------------
module frv_dmem_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          SIZE_W    = 16
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              mem_req,
    input  logic              mem_wen,
    input  logic [3:0]        mem_strb,
    input  logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_addr,
    output logic              mem_gnt,
    output logic              mem_recv,
    input  logic              mem_ack,
    output logic              mem_error,
    output logic [31:0]       mem_rdata,
    output logic              sram_cs,
    output logic              sram_wen,
    output logic [3:0]        sram_strb,
    output logic [SIZE_W-3:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [31:0] WIN_MASK = (32'd1 << SIZE_W) - 32'd1;

    // Response FIFO state
    logic [2:0]  count_r;
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [31:0] fifo_data_r [0:3];
    logic [3:0]  fifo_err_r;

    // Inflight register: the request accepted in the previous cycle
    logic        infl_valid_r;
    logic        infl_error_r;
    logic        infl_read_r;

    logic [2:0]  used_s;
    logic        accept_s;
    logic        in_range_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] push_data_s;

    // Grant and window decode; grant only looks at state, never at mem_ack
    always_comb begin
        used_s     = count_r + {2'b00, infl_valid_r};
        in_range_s = ((mem_addr & ~WIN_MASK) == BASE_ADDR);
        if (mem_req && g_resetn && (used_s < 3'd4)) begin
            mem_gnt = 1'b1;
        end else begin
            mem_gnt = 1'b0;
        end
        accept_s = mem_gnt;
    end

    // SRAM strobe: only accepted in-window requests touch the array
    always_comb begin
        sram_cs    = 1'b0;
        sram_wen   = 1'b0;
        sram_strb  = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'h0000_0000;
        if (accept_s && in_range_s) begin
            sram_cs    = 1'b1;
            sram_wen   = mem_wen;
            sram_strb  = mem_wen ? mem_strb : 4'b0000;
            sram_addr  = mem_addr[SIZE_W-1:2];
            sram_wdata = mem_wdata;
        end else begin
            sram_cs    = 1'b0;
            sram_wen   = 1'b0;
        end
    end

    // Push/pop decisions; the SRAM data is only meaningful for in-window reads
    always_comb begin
        push_s = infl_valid_r;
        pop_s  = (count_r != 3'd0) && mem_ack;
        if (infl_read_r && !infl_error_r) begin
            push_data_s = sram_rdata;
        end else begin
            push_data_s = 32'h0000_0000;
        end
    end

    // Response head; zeroed when nothing is pending
    always_comb begin
        mem_recv = (count_r != 3'd0);
        if (mem_recv) begin
            mem_rdata = fifo_data_r[rd_ptr_r];
            mem_error = fifo_err_r[rd_ptr_r];
        end else begin
            mem_rdata = 32'h0000_0000;
            mem_error = 1'b0;
        end
    end

    // Inflight register, FIFO pointers and occupancy count
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            infl_valid_r <= 1'b0;
            infl_error_r <= 1'b0;
            infl_read_r  <= 1'b0;
            count_r      <= 3'd0;
            wr_ptr_r     <= 2'd0;
            rd_ptr_r     <= 2'd0;
        end else begin
            if (accept_s) begin
                infl_valid_r <= 1'b1;
                infl_error_r <= !in_range_s;
                infl_read_r  <= !mem_wen;
            end else begin
                infl_valid_r <= 1'b0;
                infl_error_r <= 1'b0;
                infl_read_r  <= 1'b0;
            end

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            // Simultaneous push and pop leaves the count unchanged
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage write port
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_r[i] <= 32'h0000_0000;
            end
            fifo_err_r <= 4'b0000;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= push_data_s;
                fifo_err_r[wr_ptr_r]  <= infl_error_r;
            end else begin
                fifo_err_r <= fifo_err_r;
            end
        end
    end

endmodule

// File: tb/tb_frv_dmem_sram.sv
module tb_frv_dmem_sram;

    logic        clk;
    logic        resetn;
    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;
    logic        sram_cs;
    logic        sram_wen;
    logic [3:0]  sram_strb;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int errors = 0;
    int checks = 0;

    frv_dmem_sram #(
        .BASE_ADDR (32'h8000_0000),
        .SIZE_W    (16)
    ) dut (
        .g_clk      (clk),
        .g_resetn   (resetn),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_recv   (mem_recv),
        .mem_ack    (mem_ack),
        .mem_error  (mem_error),
        .mem_rdata  (mem_rdata),
        .sram_cs    (sram_cs),
        .sram_wen   (sram_wen),
        .sram_strb  (sram_strb),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 64 words, word i = 0x1111_0000 + i, word 4 = 0xDEADBEEF
    logic [31:0] sram_mem [0:63];
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 64; i++) begin
                sram_mem[i] <= 32'h1111_0000 + i;
            end
            sram_mem[4] <= 32'hDEAD_BEEF;
            sram_rdata  <= 32'h0;
        end else if (sram_cs && sram_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_strb[b]) sram_mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end else if (sram_cs) begin
            sram_rdata <= sram_mem[sram_addr[5:0]];
        end
    end

    typedef struct {
        logic        req;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        ack;
        logic        gnt;
        logic        cs;
        logic        swen;
        logic [3:0]  sstrb;
        logic [13:0] saddr;
        logic        recv;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic w, input logic [3:0] st, input logic [31:0] wd,
                       input logic [31:0] a, input logic ak, input logic g, input logic c,
                       input logic sw, input logic [3:0] ss, input logic [13:0] sa,
                       input logic rv, input logic e, input logic [31:0] rd);
        vec_t v;
        v.req = r; v.wen = w; v.strb = st; v.wdata = wd; v.addr = a; v.ack = ak;
        v.gnt = g; v.cs = c; v.swen = sw; v.sstrb = ss; v.saddr = sa;
        v.recv = rv; v.err = e; v.rdata = rd;
        vq.push_back(v);
    endtask

    task automatic add_rd(input logic [31:0] a, input logic c, input logic [13:0] sa,
                          input logic rv, input logic e, input logic [31:0] rd);
        add(1'b1, 1'b0, 4'h0, 32'h0, a, 1'b1, 1'b1, c, 1'b0, 4'h0, sa, rv, e, rd);
    endtask

    task automatic add_idle(input logic rv, input logic e, input logic [31:0] rd);
        add(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0, rv, e, rd);
    endtask

    task automatic check_resp(input string name, input logic rv, input logic e, input logic [31:0] rd);
        check({name, "_recv"}, {31'h0, mem_recv}, {31'h0, rv});
        check({name, "_error"}, {31'h0, mem_error}, {31'h0, e});
        check({name, "_rdata"}, mem_rdata, rd);
    endtask

    logic [31:0] exp_q[$];
    int          idx;
    int          got;

    initial begin
        resetn    = 1'b0;
        mem_req   = 1'b1;
        mem_wen   = 1'b0;
        mem_strb  = 4'h0;
        mem_wdata = 32'h0;
        mem_addr  = 32'h8000_0000;
        mem_ack   = 1'b0;

        // Reset state, with a request pending to show grant is blocked
        repeat (2) @(posedge clk);
        #3;
        check("rst_gnt", {31'h0, mem_gnt}, 32'h0);
        check("rst_sram_cs", {31'h0, sram_cs}, 32'h0);
        check("rst_sram_wen", {31'h0, sram_wen}, 32'h0);
        check("rst_sram_strb", {28'h0, sram_strb}, 32'h0);
        check_resp("rst", 1'b0, 1'b0, 32'h0);
        mem_req = 1'b0;
        resetn  = 1'b1;

        // Vector table: one row per cycle
        // Single read of word 4
        add_rd(32'h8000_0010, 1'b1, 14'd4, 1'b0, 1'b0, 32'h0);
        add_idle(1'b0, 1'b0, 32'h0);
        add_idle(1'b1, 1'b0, 32'hDEAD_BEEF);
        add_idle(1'b0, 1'b0, 32'h0);
        // Four back-to-back reads, ack held high
        add_rd(32'h8000_0000, 1'b1, 14'd0, 1'b0, 1'b0, 32'h0);
        add_rd(32'h8000_0004, 1'b1, 14'd1, 1'b0, 1'b0, 32'h0);
        add_rd(32'h8000_0008, 1'b1, 14'd2, 1'b1, 1'b0, 32'h1111_0000);
        add_rd(32'h8000_000C, 1'b1, 14'd3, 1'b1, 1'b0, 32'h1111_0001);
        add_idle(1'b1, 1'b0, 32'h1111_0002);
        add_idle(1'b1, 1'b0, 32'h1111_0003);
        add_idle(1'b0, 1'b0, 32'h0);
        // Partial write to word 1, then read it back
        add(1'b1, 1'b1, 4'b0011, 32'h1234_ABCD, 32'h8000_0004, 1'b1,
            1'b1, 1'b1, 1'b1, 4'b0011, 14'd1, 1'b0, 1'b0, 32'h0);
        add_idle(1'b0, 1'b0, 32'h0);
        add_idle(1'b1, 1'b0, 32'h0);
        add_rd(32'h8000_0004, 1'b1, 14'd1, 1'b0, 1'b0, 32'h0);
        add_idle(1'b0, 1'b0, 32'h0);
        add_idle(1'b1, 1'b0, 32'h1111_ABCD);
        // Out-of-window read
        add_rd(32'h0000_1000, 1'b0, 14'd0, 1'b0, 1'b0, 32'h0);
        add_idle(1'b0, 1'b0, 32'h0);
        add_idle(1'b1, 1'b1, 32'h0);
        add_idle(1'b0, 1'b0, 32'h0);
        // Window edges: last word inside, first byte beyond
        add_rd(32'h8000_FFFC, 1'b1, 14'h3FFF, 1'b0, 1'b0, 32'h0);
        add_rd(32'h8001_0000, 1'b0, 14'd0, 1'b0, 1'b0, 32'h0);
        add_idle(1'b1, 1'b0, 32'h1111_003F);
        add_idle(1'b1, 1'b1, 32'h0);
        add_idle(1'b0, 1'b0, 32'h0);

        // First table row is the first cycle after reset release
        step();
        for (int i = 0; i < vq.size(); i++) begin
            mem_req   = vq[i].req;
            mem_wen   = vq[i].wen;
            mem_strb  = vq[i].strb;
            mem_wdata = vq[i].wdata;
            mem_addr  = vq[i].addr;
            mem_ack   = vq[i].ack;
            #2;
            check($sformatf("v%0d_gnt", i), {31'h0, mem_gnt}, {31'h0, vq[i].gnt});
            check($sformatf("v%0d_sram_cs", i), {31'h0, sram_cs}, {31'h0, vq[i].cs});
            check($sformatf("v%0d_sram_wen", i), {31'h0, sram_wen}, {31'h0, vq[i].swen});
            if (vq[i].cs) begin
                check($sformatf("v%0d_sram_strb", i), {28'h0, sram_strb}, {28'h0, vq[i].sstrb});
                check($sformatf("v%0d_sram_addr", i), {18'h0, sram_addr}, {18'h0, vq[i].saddr});
                if (vq[i].swen) check($sformatf("v%0d_sram_wdata", i), sram_wdata, vq[i].wdata);
            end
            check_resp($sformatf("v%0d", i), vq[i].recv, vq[i].err, vq[i].rdata);
            step();
        end

        // Backpressure: ack held low, reads of words 8.. requested every cycle
        mem_req = 1'b1;
        mem_wen = 1'b0;
        mem_ack = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            mem_addr = 32'h8000_0000 + 32'((8 + idx) * 4);
            #2;
            check($sformatf("bp%0d_gnt", c), {31'h0, mem_gnt}, (c < 4) ? 32'h1 : 32'h0);
            if (mem_gnt) idx++;
            if (c >= 2) check_resp($sformatf("bp%0d", c), 1'b1, 1'b0, 32'h1111_0008);
            step();
        end
        check("bp_accepts", idx, 4);
        // One ack: grant stays low this cycle, reopens next cycle
        mem_addr = 32'h8000_0000 + 32'((8 + idx) * 4);
        mem_ack  = 1'b1;
        #2;
        check("bp_ack_gnt", {31'h0, mem_gnt}, 32'h0);
        check_resp("bp_ack", 1'b1, 1'b0, 32'h1111_0008);
        step();
        mem_ack = 1'b0;
        #2;
        check("bp_reopen_gnt", {31'h0, mem_gnt}, 32'h1);
        check_resp("bp_reopen", 1'b1, 1'b0, 32'h1111_0009);
        step();
        mem_req = 1'b0;
        mem_ack = 1'b1;
        exp_q = '{32'h1111_0009, 32'h1111_000A, 32'h1111_000B, 32'h1111_000C};
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (mem_recv) begin
                if (got < 4) check($sformatf("drain%0d_rdata", got), mem_rdata, exp_q[got]);
                got++;
            end
            step();
        end
        check("drain_count", got, 4);
        check("drain_empty", {31'h0, mem_recv}, 32'h0);

        // Reset with one response queued and one inflight
        mem_ack  = 1'b0;
        mem_req  = 1'b1;
        mem_addr = 32'h8000_0014;
        step();
        mem_addr = 32'h8000_0018;
        step();
        mem_req = 1'b0;
        #1;
        check("prerst_recv", {31'h0, mem_recv}, 32'h1);
        #1;
        resetn = 1'b0;
        #1;
        check_resp("midrst", 1'b0, 1'b0, 32'h0);
        mem_req = 1'b1;
        #1;
        check("midrst_gnt", {31'h0, mem_gnt}, 32'h0);
        check("midrst_sram_cs", {31'h0, sram_cs}, 32'h0);
        mem_req = 1'b0;
        step();
        step();
        #2;
        resetn = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("postrst%0d_recv", c), {31'h0, mem_recv}, 32'h0);
            step();
        end
        mem_req  = 1'b1;
        mem_addr = 32'h8000_0010;
        #2;
        check("postrst_gnt", {31'h0, mem_gnt}, 32'h1);
        step();
        mem_req = 1'b0;
        step();
        #2;
        check_resp("postrst_resp", 1'b1, 1'b0, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
